// File: rtl/uart_tx_arbiter_if.sv
// Bundle of all non-clock signals between uart_tx_arbiter and its neighbours:
// the CPU byte path, the SNN output-buffer burst request, the output-buffer
// read port and the SerialTransmitter handshake. The arbiter uses the slave view.
interface uart_tx_arbiter_if #(
    parameter int ADDR_W      = 8,
    parameter int MAX_WORDS_W = 8
);
    logic [7:0]             i_cpu_dat;
    logic                   i_cpu_wren;
    logic                   o_cpu_full;
    logic                   o_cpu_empty;
    logic                   i_hp_start;
    logic [MAX_WORDS_W-1:0] i_hp_words;
    logic                   o_hp_busy;
    logic                   o_hp_done;
    logic                   o_buf_ren;
    logic [ADDR_W-1:0]      o_buf_addr;
    logic [31:0]            i_buf_dat;
    logic [7:0]             o_tx_data;
    logic                   o_tx_send;
    logic                   i_tx_ready;

    modport slave (
        input  i_cpu_dat, i_cpu_wren, i_hp_start, i_hp_words, i_buf_dat, i_tx_ready,
        output o_cpu_full, o_cpu_empty, o_hp_busy, o_hp_done, o_buf_ren, o_buf_addr,
               o_tx_data, o_tx_send
    );

    modport master (
        output i_cpu_dat, i_cpu_wren, i_hp_start, i_hp_words, i_buf_dat, i_tx_ready,
        input  o_cpu_full, o_cpu_empty, o_hp_busy, o_hp_done, o_buf_ren, o_buf_addr,
               o_tx_data, o_tx_send
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one SerialTransmitter between the CPU byte FIFO and a high-priority
// burst that dumps 32-bit output-buffer words little-endian, byte by byte.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | choose next job: pending burst first, then CPU FIFO
// CPU_SEND | wait for ready, send FIFO head and pop it
// HP_RD    | output-buffer read of the current word index
// HP_LATCH | capture the read word, byte select back to 0
// HP_SEND  | wait for ready, send the selected byte of the word
// TX_WAIT  | one cycle while the transmitter drops its ready
// TX_RDY   | wait for ready, then next byte / next word / done / IDLE
// HP_DONE  | one-cycle done pulse, release the burst request
module uart_tx_arbiter #(
    parameter int CPU_FIFO_DEPTH = 4,
    parameter int ADDR_W         = 8,
    parameter int MAX_WORDS_W    = 8
) (
    input logic              wb_clk,
    input logic              wb_rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(CPU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE, CPU_SEND, HP_RD, HP_LATCH, HP_SEND, TX_WAIT, TX_RDY, HP_DONE
    } state_t;

    state_t                 state;
    state_t                 disp_state;
    logic [7:0]             fifo_mem [CPU_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   hp_busy;
    logic [MAX_WORDS_W-1:0] hp_words;
    logic [MAX_WORDS_W-1:0] idx;
    logic [MAX_WORDS_W-1:0] idx_next;
    logic [1:0]             sel;
    logic [31:0]            word_q;
    logic                   cpu_inflight;
    logic                   buf_ren;
    logic [ADDR_W-1:0]      buf_addr;
    logic                   hp_done;
    logic [7:0]             tx_data_q;
    logic                   send_cpu;
    logic                   send_hp;
    logic                   tx_fire;
    logic [7:0]             cand;

    assign full     = (count == CNT_W'(CPU_FIFO_DEPTH));
    assign push     = bus.i_cpu_wren && !full;
    assign send_cpu = (state == CPU_SEND) && bus.i_tx_ready;
    assign send_hp  = (state == HP_SEND) && bus.i_tx_ready;
    assign pop      = send_cpu;
    // A send in the reset cycle would start a frame the FSM is about to forget.
    assign tx_fire  = (send_cpu || send_hp) && !wb_rst;
    assign cand     = send_cpu ? fifo_mem[rd_ptr] : word_q[{sel, 3'b000} +: 8];
    assign idx_next = idx + 1'b1;

    assign bus.o_cpu_full  = full;
    assign bus.o_cpu_empty = (count == '0) && !cpu_inflight;
    assign bus.o_hp_busy   = hp_busy;
    assign bus.o_hp_done   = hp_done;
    assign bus.o_buf_ren   = buf_ren;
    assign bus.o_buf_addr  = buf_addr;
    assign bus.o_tx_send   = tx_fire;
    // Show the new byte in its send cycle, then hold it until the next send.
    assign bus.o_tx_data   = tx_fire ? cand : tx_data_q;

    // Job selection used from IDLE and straight after a CPU byte completes.
    always_comb begin
        disp_state = IDLE;
        if (hp_busy) begin
            disp_state = (hp_words == '0) ? HP_DONE : HP_RD;
        end else if (count != '0) begin
            disp_state = CPU_SEND;
        end
    end

    // CPU FIFO storage; contents need no reset because count guards reads.
    always_ff @(posedge wb_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.i_cpu_dat;
        end
    end

    // CPU FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Arbitration and byte sequencing FSM with registered read/done outputs.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state        <= IDLE;
            hp_busy      <= 1'b0;
            hp_words     <= '0;
            idx          <= '0;
            sel          <= '0;
            word_q       <= '0;
            cpu_inflight <= 1'b0;
            buf_ren      <= 1'b0;
            buf_addr     <= '0;
            hp_done      <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            buf_ren <= 1'b0;
            hp_done <= 1'b0;
            if (bus.i_hp_start && !hp_busy) begin
                hp_busy  <= 1'b1;
                hp_words <= bus.i_hp_words;
            end
            if (send_cpu || send_hp) begin
                tx_data_q <= cand;
            end
            case (state)
                IDLE: begin
                    state <= disp_state;
                    if (disp_state == HP_RD) begin
                        idx      <= '0;
                        buf_ren  <= 1'b1;
                        buf_addr <= '0;
                    end
                    if (disp_state == HP_DONE) hp_done <= 1'b1;
                end
                CPU_SEND: begin
                    if (bus.i_tx_ready) begin
                        cpu_inflight <= 1'b1;
                        state        <= TX_WAIT;
                    end
                end
                HP_RD: begin
                    state <= HP_LATCH;
                end
                HP_LATCH: begin
                    word_q <= bus.i_buf_dat;
                    sel    <= '0;
                    state  <= HP_SEND;
                end
                HP_SEND: begin
                    if (bus.i_tx_ready) state <= TX_WAIT;
                end
                TX_WAIT: begin
                    state <= TX_RDY;
                end
                TX_RDY: begin
                    if (bus.i_tx_ready) begin
                        if (cpu_inflight) begin
                            // Fold the IDLE decision in so back-to-back CPU bytes stay 3 cycles apart.
                            cpu_inflight <= 1'b0;
                            state        <= disp_state;
                            if (disp_state == HP_RD) begin
                                idx      <= '0;
                                buf_ren  <= 1'b1;
                                buf_addr <= '0;
                            end
                            if (disp_state == HP_DONE) hp_done <= 1'b1;
                        end else if (sel != 2'd3) begin
                            sel   <= sel + 1'b1;
                            state <= HP_SEND;
                        end else if (idx_next < hp_words) begin
                            idx      <= idx_next;
                            buf_ren  <= 1'b1;
                            buf_addr <= ADDR_W'(idx_next);
                            state    <= HP_RD;
                        end else begin
                            hp_done <= 1'b1;
                            state   <= HP_DONE;
                        end
                    end
                end
                HP_DONE: begin
                    hp_busy <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected bytes (with send cycles) and
// buffer read addresses are queued at stimulus time; a negedge monitor pops
// and compares whenever the DUT sends a byte or reads the output buffer.
module tb_uart_tx_arbiter;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int WW    = 8;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic wb_clk = 1'b0;
    logic wb_rst = 1'b1;

    uart_tx_arbiter_if #(.ADDR_W(AW), .MAX_WORDS_W(WW)) bus ();

    uart_tx_arbiter #(
        .CPU_FIFO_DEPTH(DEPTH),
        .ADDR_W(AW),
        .MAX_WORDS_W(WW)
    ) dut (
        .wb_clk(wb_clk),
        .wb_rst(wb_rst),
        .bus(bus)
    );

    always #5 wb_clk = ~wb_clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_sends = 0;
    int         n_reads = 0;
    int         n_done  = 0;
    int         last_done = -1;
    logic       prev_send = 1'b0;
    exp_t       exp_q[$];
    int         exp_addr[$];
    logic [31:0] mem [4];

    always @(posedge wb_clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: scoreboard pop on each send, address check and data return on each read.
    always @(negedge wb_clk) begin
        exp_t e;
        if (bus.o_tx_send) begin
            n_sends++;
            chk("send_not_back_to_back", {63'd0, prev_send}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_send_data", {56'd0, bus.o_tx_data}, 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("send_data", {56'd0, bus.o_tx_data}, {56'd0, e.d});
                if (e.c >= 0) chk("send_cycle", 64'(cyc), 64'(e.c));
            end
        end
        prev_send = bus.o_tx_send;
        if (bus.o_buf_ren) begin
            n_reads++;
            bus.i_buf_dat = mem[bus.o_buf_addr[1:0]];
            if (exp_addr.size() == 0) chk("unexpected_read_addr", {56'd0, bus.o_buf_addr}, 64'hFFFF_FFFF);
            else chk("read_addr", {56'd0, bus.o_buf_addr}, 64'(exp_addr.pop_front()));
        end
        if (bus.o_hp_done) begin
            n_done++;
            last_done = cyc;
        end
    end

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic exp_push(input logic [7:0] d, input int c);
        exp_t e;
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {44'd0, bus.o_cpu_full, bus.o_cpu_empty, bus.o_hp_busy, bus.o_hp_done,
                   bus.o_buf_ren, bus.o_buf_addr, bus.o_tx_data, bus.o_tx_send},
            {44'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (!(bus.o_cpu_empty && !bus.o_hp_busy && exp_q.size() == 0) && k < budget) begin
            tick();
            k++;
        end
        chk(name, {63'd0, k < budget}, 64'd1);
    endtask

    initial begin
        int t0;
        int s0;
        int r0;
        int d0;
        bus.i_cpu_dat  = 8'h00;
        bus.i_cpu_wren = 1'b0;
        bus.i_hp_start = 1'b0;
        bus.i_hp_words = '0;
        bus.i_tx_ready = 1'b0;
        mem[0] = 32'h1122_3344;
        mem[1] = 32'hAABB_CCDD;
        mem[2] = 32'h0;
        mem[3] = 32'h0;

        repeat (3) tick();
        @(negedge wb_clk);
        chk_reset_outputs("reset_outputs");
        wb_rst = 1'b0;
        tick();

        // Three CPU bytes with ready held high: sends 2, 5, 8 cycles after the first push.
        bus.i_tx_ready = 1'b1;
        t0 = cyc;
        bus.i_cpu_wren = 1'b1;
        bus.i_cpu_dat = 8'h41; exp_push(8'h41, t0 + 2); tick();
        bus.i_cpu_dat = 8'h42; exp_push(8'h42, t0 + 5); tick();
        bus.i_cpu_dat = 8'h43; exp_push(8'h43, t0 + 8); tick();
        bus.i_cpu_wren = 1'b0;
        wait_idle("cpu3_timeout", 40);
        chk("cpu3_empty", {63'd0, bus.o_cpu_empty}, 64'd1);

        // FIFO overflow: ready low, five pushes, fifth is dropped.
        bus.i_tx_ready = 1'b0;
        s0 = n_sends;
        bus.i_cpu_wren = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_cpu_dat = 8'h50 + 8'(i);
            exp_push(8'h50 + 8'(i), -1);
            tick();
        end
        chk("ovf_full_after_4", {63'd0, bus.o_cpu_full}, 64'd1);
        bus.i_cpu_dat = 8'h54;
        tick();
        bus.i_cpu_wren = 1'b0;
        repeat (3) tick();
        chk("ovf_no_send_while_not_ready", 64'(n_sends - s0), 64'd0);
        bus.i_tx_ready = 1'b1;
        wait_idle("ovf_timeout", 60);
        repeat (4) tick();
        chk("ovf_send_count", 64'(n_sends - s0), 64'd4);

        // Two-word burst: first byte 4 cycles after start, done at start+30.
        d0 = n_done;
        r0 = n_reads;
        t0 = cyc;
        exp_addr.push_back(0);
        exp_addr.push_back(1);
        bus.i_hp_words = 8'd2;
        bus.i_hp_start = 1'b1;
        exp_push(8'h44, t0 + 4);  exp_push(8'h33, t0 + 7);
        exp_push(8'h22, t0 + 10); exp_push(8'h11, t0 + 13);
        exp_push(8'hDD, t0 + 18); exp_push(8'hCC, t0 + 21);
        exp_push(8'hBB, t0 + 24); exp_push(8'hAA, t0 + 27);
        tick();
        bus.i_hp_start = 1'b0;
        chk("hp_busy_set", {63'd0, bus.o_hp_busy}, 64'd1);
        wait_idle("hp_timeout", 80);
        chk("hp_done_count", 64'(n_done - d0), 64'd1);
        chk("hp_done_cycle", 64'(last_done), 64'(t0 + 30));
        chk("hp_read_count", 64'(n_reads - r0), 64'd2);
        chk("hp_busy_clear", {63'd0, bus.o_hp_busy}, 64'd0);

        // Arbitration: CPU byte in flight, two queued, burst requested; a second start is ignored.
        d0 = n_done;
        r0 = n_reads;
        t0 = cyc;
        bus.i_cpu_wren = 1'b1;
        bus.i_cpu_dat = 8'h61; exp_push(8'h61, t0 + 2); tick();
        bus.i_cpu_dat = 8'h62; tick();
        bus.i_cpu_dat = 8'h63; tick();
        bus.i_cpu_wren = 1'b0;
        bus.i_hp_words = 8'd1;
        bus.i_hp_start = 1'b1;
        exp_addr.push_back(0);
        exp_push(8'h44, t0 + 7);  exp_push(8'h33, t0 + 10);
        exp_push(8'h22, t0 + 13); exp_push(8'h11, t0 + 16);
        exp_push(8'h62, t0 + 21); exp_push(8'h63, t0 + 24);
        tick();
        bus.i_hp_start = 1'b0;
        repeat (4) tick();
        bus.i_hp_words = 8'd5;
        bus.i_hp_start = 1'b1;
        tick();
        bus.i_hp_start = 1'b0;
        wait_idle("arb_timeout", 80);
        chk("arb_done_count", 64'(n_done - d0), 64'd1);
        chk("arb_done_cycle", 64'(last_done), 64'(t0 + 19));
        chk("arb_read_count", 64'(n_reads - r0), 64'd1);

        // Zero-length burst: done 2 cycles after start, nothing read or sent.
        d0 = n_done;
        r0 = n_reads;
        s0 = n_sends;
        t0 = cyc;
        bus.i_hp_words = 8'd0;
        bus.i_hp_start = 1'b1;
        tick();
        bus.i_hp_start = 1'b0;
        wait_idle("zero_timeout", 20);
        chk("zero_done_count", 64'(n_done - d0), 64'd1);
        chk("zero_done_cycle", 64'(last_done), 64'(t0 + 2));
        chk("zero_no_reads", 64'(n_reads - r0), 64'd0);
        chk("zero_no_sends", 64'(n_sends - s0), 64'd0);

        // Reset during HP_SEND of the second byte, then a fresh burst from address 0.
        d0 = n_done;
        t0 = cyc;
        bus.i_hp_words = 8'd2;
        bus.i_hp_start = 1'b1;
        exp_addr.push_back(0);
        exp_push(8'h44, t0 + 4);
        tick();
        bus.i_hp_start = 1'b0;
        repeat (6) tick();
        wb_rst = 1'b1;
        tick();
        @(negedge wb_clk);
        chk_reset_outputs("rst_mid_outputs");
        wb_rst = 1'b0;
        chk("rst_mid_no_done", 64'(n_done - d0), 64'd0);
        chk("rst_mid_pending_bytes", 64'(exp_q.size()), 64'd0);
        tick();
        d0 = n_done;
        t0 = cyc;
        bus.i_hp_words = 8'd1;
        bus.i_hp_start = 1'b1;
        exp_addr.push_back(0);
        exp_push(8'h44, t0 + 4);  exp_push(8'h33, t0 + 7);
        exp_push(8'h22, t0 + 10); exp_push(8'h11, t0 + 13);
        tick();
        bus.i_hp_start = 1'b0;
        wait_idle("rst_new_burst_timeout", 60);
        chk("rst_new_burst_done", 64'(n_done - d0), 64'd1);

        repeat (4) tick();
        chk("final_bytes_drained", 64'(exp_q.size()), 64'd0);
        chk("final_reads_drained", 64'(exp_addr.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
